// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  // All-ones quotient reported for a zero divisor; callers slice to their width.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

  // Width of the per-bit iteration counter, which must hold values up to n-1.
  function automatic int count_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/Substractor_nBits.sv
// rtl/Substractor_nBits.sv - n-bit ripple-borrow subtractor R = A - B - Bin
module Substractor_nBits #(
  parameter int n = 4
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         Bin,
  output logic [n-1:0] R,
  output logic         Bout
);

  logic [n:0] borrow;

  // Ripple the borrow from the LSB upward, one full-subtractor cell per bit.
  always_comb begin
    borrow    = '0;
    R         = '0;
    borrow[0] = Bin;
    for (int i = 0; i < n; i++) begin
      R[i]        = A[i] ^ B[i] ^ borrow[i];
      borrow[i+1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow[i]);
    end
    Bout = borrow[n];
  end

endmodule

// File: rtl/seq_divider_nbits.sv
// rtl/seq_divider_nbits.sv - multi-cycle unsigned restoring divider
module seq_divider_nbits
  import div_pkg::*;
#(
  parameter int bits = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [bits-1:0] dividend,
  input  logic [bits-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [bits-1:0] quotient,
  output logic [bits-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = count_width(bits);

  div_state_e      state_q, state_d;
  logic [bits-1:0] q_q, q_d;
  logic [bits-1:0] d_q, d_d;
  logic [bits:0]   p_q, p_d;
  logic [CW-1:0]   count_q, count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [bits-1:0] quotient_q, quotient_d;
  logic [bits-1:0] remainder_q, remainder_d;
  logic            div_by_zero_q, div_by_zero_d;

  logic [bits:0]   s_w;
  logic [bits:0]   t_w;
  logic            no_fit_w;
  logic [bits:0]   p_step;
  logic [bits-1:0] q_step;

  // The partial remainder stays below the divisor, so its top bit is always zero.
  logic unused_p_msb;
  assign unused_p_msb = p_q[bits];

  assign s_w = {p_q[bits-1:0], q_q[bits-1]};

  Substractor_nBits #(.n(bits + 1)) u_trial_sub (
    .A    (s_w),
    .B    ({1'b0, d_q}),
    .Bin  (1'b0),
    .R    (t_w),
    .Bout (no_fit_w)
  );

  // Restoring step: keep the difference and shift in 1 only when the divisor fits.
  always_comb begin
    p_step = no_fit_w ? s_w : t_w;
    q_step = {q_q[bits-2:0], ~no_fit_w};
  end

  // Next-state and datapath control; results are loaded together with done.
  always_comb begin
    state_d       = state_q;
    q_d           = q_q;
    d_d           = d_q;
    p_d           = p_q;
    count_d       = count_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d           = dividend;
          d_d           = divisor;
          p_d           = '0;
          count_d       = CW'(bits - 1);
          busy_d        = 1'b1;
          div_by_zero_d = 1'b0;
          if (divisor == '0) begin
            state_d       = FINISH;
            done_d        = 1'b1;
            quotient_d    = DIV0_QUOTIENT[bits-1:0];
            remainder_d   = dividend;
            div_by_zero_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        p_d = p_step;
        q_d = q_step;
        if (count_q == '0) begin
          state_d     = FINISH;
          done_d      = 1'b1;
          quotient_d  = q_step;
          remainder_d = p_step[bits-1:0];
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      q_q           <= '0;
      d_q           <= '0;
      p_q           <= '0;
      count_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      q_q           <= q_d;
      d_q           <= d_d;
      p_q           <= p_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider_nbits.sv
// tb/tb_seq_divider_nbits.sv - scoreboard bench for the sequential divider
module tb_seq_divider_nbits;

  localparam int BITS = 32;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [BITS-1:0] dividend;
  logic [BITS-1:0] divisor;
  logic            busy;
  logic            done;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;
  logic            div_by_zero;

  int n_tests;
  int n_fail;
  int done_count;

  logic [2*BITS:0] sb[$];

  seq_divider_nbits #(.bits(BITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*BITS:0] ref_model(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    longint unsigned ua, ub;
    logic [BITS-1:0] q, r;
    ua = 64'(a);
    ub = 64'(b);
    if (ub == 0) return {1'b1, {BITS{1'b1}}, a};
    q = BITS'(ua / ub);
    r = BITS'(ua % ub);
    return {1'b0, q, r};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [2*BITS:0] e;
      done_count++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        e = sb.pop_front();
        chk("quotient", 64'(quotient), 64'(e[2*BITS-1:BITS]));
        chk("remainder", 64'(remainder), 64'(e[BITS-1:0]));
        chk("div_by_zero", 64'(div_by_zero), 64'(e[2*BITS]));
      end
    end
  end

  // Issue one operation and wait (bounded) for its done pulse.
  task automatic run_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input bit chk_lat);
    int lat, busy_cnt;
    bit got;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(ref_model(a, b));
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat = 1;
    busy_cnt = 0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (!got) chk("done_timeout", 64'(0), 64'(1));
    if (chk_lat && got) begin
      chk("latency", 64'(lat), (b == 0) ? 64'(1) : 64'(BITS + 1));
      chk("busy_cycles", 64'(busy_cnt), (b == 0) ? 64'(1) : 64'(BITS + 1));
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("busy_after_done", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    int dc0;
    bit got;
    logic [BITS-1:0] ra, rb;
    n_tests = 0;
    n_fail = 0;
    done_count = 0;
    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_quotient", 64'(quotient), 64'(0));
    chk("rst_remainder", 64'(remainder), 64'(0));
    chk("rst_div_by_zero", 64'(div_by_zero), 64'(0));
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b1);
    run_op(32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op(32'h1234, 32'd0, 1'b1);
    run_op(32'd50, 32'd6, 1'b1);

    // Start held high with changing operands for the whole operation.
    dc0 = done_count;
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    sb.push_back(ref_model(32'd1000, 32'd3));
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      dividend = $urandom;
      divisor  = $urandom_range(1, 1000);
    end
    start = 1'b0;
    if (!got) chk("pulsed_timeout", 64'(0), 64'(1));
    repeat (40) @(negedge clk);
    chk("pulsed_single_done", 64'(done_count - dc0), 64'(1));

    // Reset in the middle of a calculation.
    @(negedge clk);
    dividend = 32'd200;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    dc0 = done_count;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_quotient", 64'(quotient), 64'(0));
    chk("abort_remainder", 64'(remainder), 64'(0));
    chk("abort_div_by_zero", 64'(div_by_zero), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 64'(done_count - dc0), 64'(0));
    run_op(32'd81, 32'd9, 1'b1);

    // Randomized back-to-back operations with mixed divisor magnitudes.
    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = 32'd1 << $urandom_range(0, 31);
        default: rb = ra >> $urandom_range(0, 31);
      endcase
      if (rb == 0) rb = 32'd1;
      run_op(ra, rb, 1'b0);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
